// File: rtl/bp_fpga_dma_arb_pkg.sv
// Shared types and helpers for the multi-channel DMA arbiter.
// The optional BP_FPGA_DMA_ARB_PERF_EN build adds per-channel performance counters to the top.
package bp_fpga_dma_arb_pkg;

    localparam int dma_caddr_width_gp = 28;

    typedef struct packed {
        logic                          write_not_read;
        logic [dma_caddr_width_gp-1:0] addr;
    } bp_fpga_dma_pkt_s;

    function automatic int beats_f(input int block_width, input int fill_width);
        return block_width / fill_width;
    endfunction

    function automatic int id_width_f(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/bp_fpga_dma_beat_router.sv
// Per-direction tag FIFO of granted channel ids plus a beat counter.
// The head id steers data beats; the FIFO pops after the last beat of a packet.
module bp_fpga_dma_beat_router
    import bp_fpga_dma_arb_pkg::*;
#(
    parameter int els_p      = 4,
    parameter int beats_p    = 8,
    parameter int id_width_p = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_v_i,
    input  logic [id_width_p-1:0] push_id_i,
    input  logic                  beat_v_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [id_width_p-1:0] head_id_o
);

    localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w  = $clog2(els_p + 1);
    localparam int beat_w = (beats_p > 1) ? $clog2(beats_p) : 1;

    logic [id_width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]      wptr, rptr;
    logic [cnt_w-1:0]      count;
    logic [beat_w-1:0]     beat_cnt;
    logic                  push, pop, last_beat;

    assign empty_o   = (count == '0);
    assign full_o    = (count == cnt_w'(els_p));
    assign head_id_o = mem[rptr];
    assign last_beat = (beat_cnt == beat_w'(beats_p - 1));
    assign push      = push_v_i & ~full_o;
    assign pop       = beat_v_i & last_beat & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= push_id_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wptr <= (wptr == ptr_w'(els_p - 1)) ? '0 : wptr + 1'b1;
            if (pop)  rptr <= (rptr == ptr_w'(els_p - 1)) ? '0 : rptr + 1'b1;
            if (push & ~pop)      count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
            if (beat_v_i & ~empty_o) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bp_fpga_dma_arbiter.sv
// Round-robin packet arbiter and in-order beat router between N cache DMA ports and one DRAM port.
// Define BP_FPGA_DMA_ARB_PERF_EN to add saturating per-channel rd/wr packet and stall counters.
module bp_fpga_dma_arbiter
    import bp_fpga_dma_arb_pkg::*;
#(
    parameter int num_dma_p      = 2,
    parameter int caddr_width_p  = 28,
    parameter int fill_width_p   = 64,
    parameter int block_width_p  = 512,
    parameter int tag_fifo_els_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_dma_p*(1+caddr_width_p)-1:0] dma_pkt_i,
    input  logic [num_dma_p-1:0]                   dma_pkt_v_i,
    output logic [num_dma_p-1:0]                   dma_pkt_yumi_o,
    output logic [num_dma_p*fill_width_p-1:0]      dma_data_o,
    output logic [num_dma_p-1:0]                   dma_data_v_o,
    input  logic [num_dma_p-1:0]                   dma_data_ready_and_i,
    input  logic [num_dma_p*fill_width_p-1:0]      dma_data_i,
    input  logic [num_dma_p-1:0]                   dma_data_v_i,
    output logic [num_dma_p-1:0]                   dma_data_yumi_o,
    output logic [caddr_width_p:0]                 mem_pkt_o,
    output logic                                   mem_pkt_v_o,
    input  logic                                   mem_pkt_yumi_i,
    input  logic [fill_width_p-1:0]                mem_data_i,
    input  logic                                   mem_data_v_i,
    output logic                                   mem_data_ready_and_o,
    output logic [fill_width_p-1:0]                mem_data_o,
    output logic                                   mem_data_v_o,
    input  logic                                   mem_data_yumi_i,
    output logic                                   error_o
`ifdef BP_FPGA_DMA_ARB_PERF_EN
    ,
    output logic [num_dma_p*32-1:0]                perf_rd_pkts_o,
    output logic [num_dma_p*32-1:0]                perf_wr_pkts_o,
    output logic [num_dma_p*32-1:0]                perf_stall_o
`endif
);

    localparam int pw_lp    = 1 + caddr_width_p;
    localparam int id_w_lp  = id_width_f(num_dma_p);
    localparam int beats_lp = beats_f(block_width_p, fill_width_p);

    logic [id_w_lp-1:0]   rr_ptr, grant_id, rd_head, wr_head;
    logic [num_dma_p-1:0] pkt_wr, eligible;
    logic                 grant_found, pkt_yumi, rd_full, rd_empty, wr_full, wr_empty;
    logic                 rd_live, wr_live, rd_hs, wr_hs, error_r;
    int                   idx;

    for (genvar i = 0; i < num_dma_p; i++) begin : g_elig
        assign pkt_wr[i]   = dma_pkt_i[i*pw_lp + pw_lp - 1];
        assign eligible[i] = dma_pkt_v_i[i] & (pkt_wr[i] ? ~wr_full : ~rd_full);
    end

    // First eligible channel scanning upward from rr_ptr, wrapping at num_dma_p.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < num_dma_p; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= num_dma_p) idx = idx - num_dma_p;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_id    = id_w_lp'(idx);
            end
        end
    end

    // Handshakes: valid/ready transfers when both are high in a cycle; yumi is a
    // consumer acknowledge that may only be raised while the matching valid is high.
    assign mem_pkt_o   = dma_pkt_i[int'(grant_id)*pw_lp +: pw_lp];
    assign mem_pkt_v_o = grant_found & ~reset_i;
    assign pkt_yumi    = mem_pkt_yumi_i & mem_pkt_v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i)       rr_ptr <= '0;
        else if (pkt_yumi) rr_ptr <= (grant_id == id_w_lp'(num_dma_p - 1)) ? '0 : grant_id + 1'b1;
    end

    bp_fpga_dma_beat_router #(.els_p(tag_fifo_els_p), .beats_p(beats_lp), .id_width_p(id_w_lp)) u_rd (
        .clk_i(clk_i), .reset_i(reset_i), .push_v_i(pkt_yumi & ~mem_pkt_o[caddr_width_p]),
        .push_id_i(grant_id), .beat_v_i(rd_hs), .full_o(rd_full), .empty_o(rd_empty),
        .head_id_o(rd_head)
    );

    bp_fpga_dma_beat_router #(.els_p(tag_fifo_els_p), .beats_p(beats_lp), .id_width_p(id_w_lp)) u_wr (
        .clk_i(clk_i), .reset_i(reset_i), .push_v_i(pkt_yumi & mem_pkt_o[caddr_width_p]),
        .push_id_i(grant_id), .beat_v_i(wr_hs), .full_o(wr_full), .empty_o(wr_empty),
        .head_id_o(wr_head)
    );

    assign rd_live              = ~rd_empty & ~reset_i;
    assign wr_live              = ~wr_empty & ~reset_i;
    assign dma_data_o           = {num_dma_p{mem_data_i}};
    assign mem_data_ready_and_o = rd_live & dma_data_ready_and_i[rd_head];
    assign rd_hs                = mem_data_v_i & mem_data_ready_and_o;
    assign mem_data_o           = dma_data_i[int'(wr_head)*fill_width_p +: fill_width_p];
    assign mem_data_v_o         = wr_live & dma_data_v_i[wr_head];
    assign wr_hs                = mem_data_yumi_i & mem_data_v_o;

    always_comb begin
        dma_pkt_yumi_o  = '0;
        dma_data_v_o    = '0;
        dma_data_yumi_o = '0;
        if (pkt_yumi)                dma_pkt_yumi_o[grant_id] = 1'b1;
        if (mem_data_v_i & rd_live)  dma_data_v_o[rd_head]    = 1'b1;
        if (wr_hs)                   dma_data_yumi_o[wr_head] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) error_r <= 1'b0;
        else         error_r <= error_r | (mem_data_v_i & rd_empty) | (mem_data_yumi_i & ~mem_data_v_o);
    end
    assign error_o = error_r;

`ifdef BP_FPGA_DMA_ARB_PERF_EN
    for (genvar i = 0; i < num_dma_p; i++) begin : g_perf
        logic [31:0] rd_c, wr_c, st_c;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                rd_c <= '0;
                wr_c <= '0;
                st_c <= '0;
            end else begin
                if (dma_pkt_yumi_o[i] & ~pkt_wr[i] & ~&rd_c) rd_c <= rd_c + 1'b1;
                if (dma_pkt_yumi_o[i] &  pkt_wr[i] & ~&wr_c) wr_c <= wr_c + 1'b1;
                if (dma_pkt_v_i[i] & ~dma_pkt_yumi_o[i] & ~&st_c) st_c <= st_c + 1'b1;
            end
        end
        assign perf_rd_pkts_o[i*32 +: 32] = rd_c;
        assign perf_wr_pkts_o[i*32 +: 32] = wr_c;
        assign perf_stall_o[i*32 +: 32]   = st_c;
    end
`endif

endmodule

// File: tb/tb_bp_fpga_dma_arbiter.sv
// Directed bench for bp_fpga_dma_arbiter: arbitration order, beat routing, back-pressure, error and reset.
module tb_bp_fpga_dma_arbiter;

    localparam int n_lp = 2;
    localparam int a_lp = 28;
    localparam int f_lp = 64;
    localparam int beats_lp = 8;

    logic                     clk, reset_i;
    logic [n_lp*(a_lp+1)-1:0] dma_pkt_i;
    logic [n_lp-1:0]          dma_pkt_v_i, dma_pkt_yumi_o;
    logic [n_lp*f_lp-1:0]     dma_data_o, dma_data_i;
    logic [n_lp-1:0]          dma_data_v_o, dma_data_ready_and_i, dma_data_v_i, dma_data_yumi_o;
    logic [a_lp:0]            mem_pkt_o;
    logic                     mem_pkt_v_o, mem_pkt_yumi_i;
    logic [f_lp-1:0]          mem_data_i, mem_data_o;
    logic                     mem_data_v_i, mem_data_ready_and_o, mem_data_v_o, mem_data_yumi_i;
    logic                     error_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    bp_fpga_dma_arbiter dut (
        .clk_i(clk), .reset_i(reset_i),
        .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
        .mem_pkt_o(mem_pkt_o), .mem_pkt_v_o(mem_pkt_v_o), .mem_pkt_yumi_i(mem_pkt_yumi_i),
        .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i), .mem_data_ready_and_o(mem_data_ready_and_o),
        .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o), .mem_data_yumi_i(mem_data_yumi_i),
        .error_o(error_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_and_i = '0; dma_data_i = '0;
        dma_data_v_i = '0; mem_pkt_yumi_i = 0; mem_data_i = '0; mem_data_v_i = 0; mem_data_yumi_i = 0;
    endtask

    task automatic do_reset();
        reset_i = 1;
        idle_inputs();
        tick();
        reset_i = 0;
        #1;
    endtask

    task automatic set_pkt(input int ch, input logic wr, input logic [a_lp-1:0] addr);
        dma_pkt_i[ch*(a_lp+1) +: a_lp+1] = {wr, addr};
        dma_pkt_v_i[ch] = 1'b1;
    endtask

    // driver: present one packet on one channel, controller accepts it
    task automatic issue_pkt(input int ch, input logic wr, input logic [a_lp-1:0] addr);
        set_pkt(ch, wr, addr);
        mem_pkt_yumi_i = 1;
        #1;
        check("pkt_v", 64'(mem_pkt_v_o), 64'd1);
        check("pkt_o", 64'(mem_pkt_o), 64'({wr, addr}));
        check("pkt_yumi", 64'(dma_pkt_yumi_o), 64'(1 << ch));
        tick();
        dma_pkt_v_i = '0;
        mem_pkt_yumi_i = 0;
    endtask

    // driver + scoreboard: controller returns n fill beats expected at channel ch
    task automatic read_beats(input int n, input int ch, input logic [63:0] base);
        logic [63:0] exp;
        dma_data_ready_and_i = '1;
        for (int b = 0; b < n; b++) begin
            mem_data_i = base + 64'(b);
            mem_data_v_i = 1;
            exp_q.push_back(base + 64'(b));
            #1;
            exp = exp_q.pop_front();
            check("rd_v", 64'(dma_data_v_o), 64'(1 << ch));
            check("rd_ready", 64'(mem_data_ready_and_o), 64'd1);
            check("rd_data", dma_data_o[ch*f_lp +: f_lp], exp);
            tick();
        end
        mem_data_v_i = 0;
        dma_data_ready_and_i = '0;
    endtask

    // driver + scoreboard: all channels offer data, only channel ch may be forwarded
    task automatic write_beats(input int n, input int ch);
        logic [63:0] exp;
        dma_data_v_i = '1;
        mem_data_yumi_i = 1;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < n_lp; c++) dma_data_i[c*f_lp +: f_lp] = 64'h1000 * (c + 1) + 64'(b);
            exp_q.push_back(64'h1000 * (ch + 1) + 64'(b));
            #1;
            exp = exp_q.pop_front();
            check("wr_v", 64'(mem_data_v_o), 64'd1);
            check("wr_data", mem_data_o, exp);
            check("wr_yumi", 64'(dma_data_yumi_o), 64'(1 << ch));
            tick();
        end
        dma_data_v_i = '0;
        mem_data_yumi_i = 0;
    endtask

    initial begin
        reset_i = 1;
        idle_inputs();
        repeat (3) tick();
        reset_i = 0;
        #1;
        check("rst_pkt_v", 64'(mem_pkt_v_o), 64'd0);
        check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        check("rst_rd_ready", 64'(mem_data_ready_and_o), 64'd0);
        check("rst_wr_v", 64'(mem_data_v_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_rr", 64'(dut.rr_ptr), 64'd0);

        // single read on ch0, beats 0..7
        issue_pkt(0, 1'b0, 28'h40);
        read_beats(beats_lp, 0, 64'd0);
        dma_data_ready_and_i = '1;
        #1;
        check("t1_rd_empty", 64'(mem_data_ready_and_o), 64'd0);
        check("t1_error", 64'(error_o), 64'd0);
        dma_data_ready_and_i = '0;

        // simultaneous requests with rr_ptr at 0
        do_reset();
        set_pkt(0, 1'b0, 28'h100);
        set_pkt(1, 1'b0, 28'h200);
        mem_pkt_yumi_i = 1;
        #1;
        check("t2_first", 64'(dma_pkt_yumi_o), 64'b01);
        check("t2_first_pkt", 64'(mem_pkt_o), 64'h100);
        tick();
        dma_pkt_v_i[0] = 1'b0;
        #1;
        check("t2_second", 64'(dma_pkt_yumi_o), 64'b10);
        check("t2_second_pkt", 64'(mem_pkt_o), 64'h200);
        tick();
        idle_inputs();
        #1;
        check("t2_rr_wrap", 64'(dut.rr_ptr), 64'd0);
        read_beats(beats_lp, 0, 64'h100);
        read_beats(beats_lp, 1, 64'h200);

        // ch1 write then ch0 read
        issue_pkt(1, 1'b1, 28'h300);
        issue_pkt(0, 1'b0, 28'h400);
        write_beats(beats_lp, 1);
        read_beats(beats_lp, 0, 64'h400);
        dma_data_v_i = '1;
        #1;
        check("t3_wr_empty", 64'(mem_data_v_o), 64'd0);
        dma_data_v_i = '0;

        // four reads fill the read tag FIFO; writes are still accepted
        for (int i = 0; i < 4; i++) issue_pkt(0, 1'b0, 28'(32'h500 + i * 64));
        set_pkt(0, 1'b0, 28'h600);
        set_pkt(1, 1'b1, 28'h700);
        mem_pkt_yumi_i = 1;
        #1;
        check("t4_wr_granted", 64'(dma_pkt_yumi_o), 64'b10);
        check("t4_wr_pkt", 64'(mem_pkt_o), 64'({1'b1, 28'h700}));
        tick();
        dma_pkt_v_i[1] = 1'b0;
        #1;
        check("t4_rd_blocked_v", 64'(mem_pkt_v_o), 64'd0);
        check("t4_rd_blocked_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        idle_inputs();
        write_beats(beats_lp, 1);
        for (int i = 0; i < 4; i++) read_beats(beats_lp, 0, 64'(32'h900 + i * 16));
        check("t4_error", 64'(error_o), 64'd0);

        // read data with nothing outstanding
        do_reset();
        mem_data_v_i = 1;
        #1;
        check("t5_err_before", 64'(error_o), 64'd0);
        tick();
        mem_data_v_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_err_sticky", 64'(error_o), 64'd1);
            tick();
        end
        do_reset();
        check("t5_err_cleared", 64'(error_o), 64'd0);

        // write yumi without write data valid
        mem_data_yumi_i = 1;
        tick();
        mem_data_yumi_i = 0;
        #1;
        check("t6_err_yumi", 64'(error_o), 64'd1);
        do_reset();

        // reset in the middle of a read burst
        issue_pkt(0, 1'b0, 28'h800);
        issue_pkt(1, 1'b1, 28'h880);
        read_beats(3, 0, 64'ha0);
        reset_i = 1;
        tick();
        reset_i = 0;
        dma_data_ready_and_i = '1;
        dma_data_v_i = '1;
        #1;
        check("t7_rd_ready", 64'(mem_data_ready_and_o), 64'd0);
        check("t7_rd_v", 64'(dma_data_v_o), 64'd0);
        check("t7_wr_v", 64'(mem_data_v_o), 64'd0);
        check("t7_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        check("t7_wr_yumi", 64'(dma_data_yumi_o), 64'd0);
        check("t7_error", 64'(error_o), 64'd0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
